gm_lpip_mdu_ctrl: RTL and testbench

//  Sequencer for the iterative multiply/divide (M-extension) unit.
//  - Accepts one decoded mul/mulh/div/rem op per handshake; the op fields come from the decoder's mhdr/op_signed/w32 outputs.
//  - Runs a radix-2 shift-add multiply or restoring divide over N cycles, applies sign correction and RISC-V special cases.
//  - Holds the result until writeback accepts it.

---
 rtl/gm_lpip_mdu_ctrl_pkg.sv | 24 ++
 rtl/gm_lpip_mdu_ctrl_if.sv | 37 +++
 rtl/gm_lpip_mdu_ctrl_iter.sv | 32 +++
 rtl/gm_lpip_mdu_ctrl.sv | 150 +++++++++++++++
 tb/tb_gm_lpip_mdu_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/gm_lpip_mdu_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op codes, operand-signedness codes and FSM state encodings.
package gm_lpip_mdu_ctrl_pkg;

  typedef logic [1:0] lpip_op_t;
  typedef logic [1:0] lpip_sgn_t;

  localparam lpip_op_t LPIP_OP_MUL  = 2'b00;
  localparam lpip_op_t LPIP_OP_MULH = 2'b01;
  localparam lpip_op_t LPIP_OP_DIV  = 2'b10;
  localparam lpip_op_t LPIP_OP_REM  = 2'b11;

  // [1] = rs1 signed, [0] = rs2 signed
  localparam lpip_sgn_t ALU_OP_UU = 2'b00;
  localparam lpip_sgn_t ALU_OP_US = 2'b01;
  localparam lpip_sgn_t ALU_OP_SU = 2'b10;
  localparam lpip_sgn_t ALU_OP_SS = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/gm_lpip_mdu_ctrl_if.sv
// Request/response bus of the multiply/divide sequencer.
// Handshake: a transfer happens on a rising clock edge where the source
// holds *_valid high and the sink drives *_ready high. The source keeps
// valid and its payload stable until that edge; ready never depends
// combinationally on valid.
interface gm_lpip_mdu_ctrl_if #(parameter int WORD_LEN = 64);
  import gm_lpip_mdu_ctrl_pkg::*;

  logic                req_valid;
  logic                req_ready;
  lpip_op_t            req_op;
  lpip_sgn_t           req_op_signed;
  logic                req_w32;
  logic [WORD_LEN-1:0] req_rs1;
  logic [WORD_LEN-1:0] req_rs2;
  logic [4:0]          req_rd_idx;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORD_LEN-1:0] rsp_result;
  logic [4:0]          rsp_rd_idx;

  modport master (
    output req_valid, req_op, req_op_signed, req_w32, req_rs1, req_rs2, req_rd_idx,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_rd_idx,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_op_signed, req_w32, req_rs1, req_rs2, req_rd_idx,
    output req_ready,
    output rsp_valid, rsp_result, rsp_rd_idx,
    input  rsp_ready
  );

endinterface

// File: rtl/gm_lpip_mdu_ctrl_iter.sv
// Single combinational iteration step on the 2*W accumulator.
// Multiply: conditional add of the multiplicand into the high half,
// then shift right one (carry enters at the top).
// Divide: shift left one, trial-subtract the divisor from the high part,
// keep the difference and shift in a 1 quotient bit when it fits.
module gm_lpip_mdu_ctrl_iter #(parameter int W = 64) (
  input  logic           i_div,
  input  logic [2*W-1:0] i_acc,
  input  logic [W-1:0]   i_opnd,
  output logic [2*W-1:0] o_acc
);

  logic [W:0]   w_sum;
  logic [W:0]   w_hi_sh;
  logic         w_fits;
  logic [W-1:0] w_rem;

  // One radix-2 step for whichever mode is active
  always_comb begin
    w_sum   = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_hi_sh = i_acc[2*W-1:W-1];
    w_fits  = (w_hi_sh >= {1'b0, i_opnd});
    w_rem   = w_hi_sh[W-1:0] - i_opnd;
    if (!i_div)
      o_acc = {w_sum, i_acc[W-1:1]};
    else if (w_fits)
      o_acc = {w_rem, i_acc[W-2:0], 1'b1};
    else
      o_acc = {w_hi_sh[W-1:0], i_acc[W-2:0], 1'b0};
  end

endmodule

// File: rtl/gm_lpip_mdu_ctrl.sv
// Sequencer for the iterative M-extension multiply/divide unit.
// IDLE -> CALC (N steps) -> FIX (sign/special cases) -> DONE -> IDLE.
// Optional macro LPIP_DIV_FAST_EN: divide-by-zero and signed-overflow
// divides bypass CALC and go straight to FIX.
module gm_lpip_mdu_ctrl
  import gm_lpip_mdu_ctrl_pkg::*;
#(
  parameter int WORD_LEN = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  gm_lpip_mdu_ctrl_if.slave  bus,
  output logic               o_busy,
  output logic [1:0]         o_dbg_state
);

  localparam int W  = WORD_LEN;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN64 = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MIN32 = {{(W-31){1'b1}}, 31'b0};

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opnd, r_ext1, r_result;
  logic           r_neg1, r_neg2, r_w32, r_div0, r_ovf, r_valid;
  lpip_op_t       r_op;
  logic [4:0]     r_tag, r_rd_idx;

  logic [W-1:0]   w_ext1, w_ext2, w_abs1, w_abs2, w_div_lo;
  logic           w_neg1, w_neg2, w_div0, w_ovf, w_skip;
  logic [2*W-1:0] w_acc_next, w_prod, w_prod_s;
  logic [W-1:0]   w_quo_s, w_rem_s, w_raw, w_final;

  gm_lpip_mdu_ctrl_iter #(.W(W)) u_iter (
    .i_div  (r_op[1]),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_next)
  );

  // Operand preparation at accept: extension, magnitudes, special cases
  always_comb begin
    w_ext1 = bus.req_rs1;
    w_ext2 = bus.req_rs2;
    if (bus.req_w32) begin
      w_ext1 = {{(W-32){bus.req_op_signed[1] & bus.req_rs1[31]}}, bus.req_rs1[31:0]};
      w_ext2 = {{(W-32){bus.req_op_signed[0] & bus.req_rs2[31]}}, bus.req_rs2[31:0]};
    end
    w_neg1   = bus.req_op_signed[1] & w_ext1[W-1];
    w_neg2   = bus.req_op_signed[0] & w_ext2[W-1];
    w_abs1   = w_neg1 ? -w_ext1 : w_ext1;
    w_abs2   = w_neg2 ? -w_ext2 : w_ext2;
    // W-form divides run 32 steps, so the dividend starts in the top half
    w_div_lo = bus.req_w32 ? (w_abs1 << (W-32)) : w_abs1;
    w_div0   = (w_ext2 == '0);
    w_ovf    = (bus.req_op_signed == ALU_OP_SS) && (w_ext2 == '1) &&
               (w_ext1 == (bus.req_w32 ? MIN32 : MIN64));
  end

`ifdef LPIP_DIV_FAST_EN
  assign w_skip = bus.req_op[1] & (w_div0 | w_ovf);
`else
  assign w_skip = 1'b0;
`endif

  // Result fix-up: sign correction, special-case override, W-form extension
  always_comb begin
    w_prod   = r_w32 ? (r_acc >> (W-32)) : r_acc;
    w_prod_s = (r_neg1 ^ r_neg2) ? -w_prod : w_prod;
    w_quo_s  = (r_neg1 ^ r_neg2) ? -r_acc[W-1:0] : r_acc[W-1:0];
    w_rem_s  = r_neg1 ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    case (r_op)
      LPIP_OP_MUL:  w_raw = w_prod_s[W-1:0];
      LPIP_OP_MULH: w_raw = r_w32 ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W];
      LPIP_OP_DIV:  w_raw = r_div0 ? '1 : (r_ovf ? (r_w32 ? MIN32 : MIN64) : w_quo_s);
      default:      w_raw = r_div0 ? r_ext1 : (r_ovf ? '0 : w_rem_s);
    endcase
    w_final = r_w32 ? {{(W-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
  end

  // FSM, iteration counter, operand latches and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_ext1   <= '0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_w32    <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_op     <= LPIP_OP_MUL;
      r_tag    <= '0;
      r_result <= '0;
      r_rd_idx <= '0;
      r_valid  <= 1'b0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_acc   <= {{W{1'b0}}, (bus.req_op[1] ? w_div_lo : w_abs1)};
            r_opnd  <= w_abs2;
            r_ext1  <= w_ext1;
            r_neg1  <= w_neg1;
            r_neg2  <= w_neg2;
            r_w32   <= bus.req_w32;
            r_div0  <= w_div0;
            r_ovf   <= w_ovf;
            r_op    <= bus.req_op;
            r_tag   <= bus.req_rd_idx;
            r_cnt   <= bus.req_w32 ? CW'(32) : CW'(W);
            r_state <= w_skip ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_final;
          r_rd_idx <= r_tag;
          r_valid  <= 1'b1;
          r_state  <= ST_DONE;
        end
        default: begin
          if (bus.rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.rsp_valid  = r_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_rd_idx = r_rd_idx;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_gm_lpip_mdu_ctrl.sv
// Directed + small random bench for gm_lpip_mdu_ctrl with a result scoreboard.
module tb_gm_lpip_mdu_ctrl;
  import gm_lpip_mdu_ctrl_pkg::*;

  localparam int W     = 64;
  localparam int LAT64 = W + 2;
  localparam int LAT32 = 32 + 2;
`ifdef LPIP_DIV_FAST_EN
  localparam int LAT_SPC64 = 2;
  localparam int LAT_SPC32 = 2;
`else
  localparam int LAT_SPC64 = LAT64;
  localparam int LAT_SPC32 = LAT32;
`endif

  logic       clk, rst_n, flush, busy;
  logic [1:0] dbg_state;
  int         checks, failures;

  logic [W-1:0] exp_q[$];
  logic [4:0]   tag_q[$];

  gm_lpip_mdu_ctrl_if #(.WORD_LEN(W)) bus();

  gm_lpip_mdu_ctrl #(.WORD_LEN(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .bus         (bus),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // driver: wait for o_ready, present op for one accept edge, push expectation
  task automatic issue(input string name, input logic [1:0] op, input logic [1:0] sgn,
                       input logic w32, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] tag, input logic [W-1:0] expv);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check({name, "_ready"}, {63'b0, bus.req_ready}, 64'd1);
    bus.req_op        = op;
    bus.req_op_signed = sgn;
    bus.req_w32       = w32;
    bus.req_rs1       = a;
    bus.req_rs2       = b;
    bus.req_rd_idx    = tag;
    bus.req_valid     = 1'b1;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // scoreboard: measure latency from accept edge, pop and compare result/tag
  task automatic wait_result(input string name, input int exp_lat);
    int lat = 1;
    logic [W-1:0] e;
    logic [4:0]   et;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
    check({name, "_lat"}, W'(lat), W'(exp_lat));
    e  = exp_q.pop_front();
    et = tag_q.pop_front();
    check({name, "_res"}, bus.rsp_result, e);
    check({name, "_tag"}, {59'b0, bus.rsp_rd_idx}, {59'b0, et});
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [1:0] sgn,
                        input logic w32, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] tag, input logic [W-1:0] expv, input int lat);
    issue(name, op, sgn, w32, a, b, tag, expv);
    wait_result(name, lat);
    ack();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         saw;
    checks = 0; failures = 0;
    rst_n = 1'b0; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_op_signed = '0; bus.req_w32 = 1'b0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd_idx = '0; bus.rsp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check("rst_result", bus.rsp_result, 64'd0);
    check("rst_rd_idx", {59'b0, bus.rsp_rd_idx}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_state", {62'b0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {63'b0, bus.req_ready}, 64'd1);

    // multiply
    run_op("mul_ss", LPIP_OP_MUL, ALU_OP_SS, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd1,
           64'hFFFF_FFFF_FFFF_FFEB, LAT64);
    run_op("mulh_uu", LPIP_OP_MULH, ALU_OP_UU, 1'b0, '1, '1, 5'd2,
           64'hFFFF_FFFF_FFFF_FFFE, LAT64);
    run_op("mulh_su", LPIP_OP_MULH, ALU_OP_SU, 1'b0, '1, 64'd2, 5'd3, '1, LAT64);
    run_op("mulw_ss", LPIP_OP_MUL, ALU_OP_SS, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 5'd4,
           64'hFFFF_FFFF_FFFF_FFFE, LAT32);
    run_op("mulhw_as_mulw", LPIP_OP_MULH, ALU_OP_SS, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd5,
           64'hFFFF_FFFF_FFFF_FFEB, LAT32);

    // divide / remainder incl. special cases
    run_op("divw_ovf", LPIP_OP_DIV, ALU_OP_SS, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd6,
           64'hFFFF_FFFF_8000_0000, LAT_SPC32);
    run_op("remw_ovf", LPIP_OP_REM, ALU_OP_SS, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd7,
           64'd0, LAT_SPC32);
    run_op("div_ovf64", LPIP_OP_DIV, ALU_OP_SS, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd8,
           64'h8000_0000_0000_0000, LAT_SPC64);
    run_op("div_ss", LPIP_OP_DIV, ALU_OP_SS, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9,
           64'hFFFF_FFFF_FFFF_FFFD, LAT64);
    run_op("rem_ss", LPIP_OP_REM, ALU_OP_SS, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10,
           '1, LAT64);
    run_op("div0_uu", LPIP_OP_DIV, ALU_OP_UU, 1'b0, 64'd42, 64'd0, 5'd11, '1, LAT_SPC64);
    run_op("rem0_uu", LPIP_OP_REM, ALU_OP_UU, 1'b0, 64'd42, 64'd0, 5'd12, 64'd42, LAT_SPC64);
    run_op("remuw0", LPIP_OP_REM, ALU_OP_UU, 1'b1, 64'h0000_0001_FFFF_FFF0, 64'h1_0000_0000, 5'd13,
           64'hFFFF_FFFF_FFFF_FFF0, LAT_SPC32);

    // random unsigned ops against the language's own arithmetic
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op("rnd_mul", LPIP_OP_MUL, ALU_OP_UU, 1'b0, ra, rb, 5'($urandom_range(0, 31)), ra * rb, LAT64);
      rb = {32'b0, $urandom} | 64'd1;
      run_op("rnd_divu", LPIP_OP_DIV, ALU_OP_UU, 1'b0, ra, rb, 5'($urandom_range(0, 31)), ra / rb, LAT64);
      run_op("rnd_remu", LPIP_OP_REM, ALU_OP_UU, 1'b0, ra, rb, 5'($urandom_range(0, 31)), ra % rb, LAT64);
    end

    // result held while writeback stalls
    issue("hold", LPIP_OP_MUL, ALU_OP_UU, 1'b0, 64'd5, 64'd6, 5'd9, 64'd30);
    wait_result("hold", LAT64);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res", bus.rsp_result, 64'd30);
      check("hold_tag", {59'b0, bus.rsp_rd_idx}, 64'd9);
      check("hold_ready", {63'b0, bus.req_ready}, 64'd0);
    end
    ack();

    // flush in the middle of CALC
    issue("flush", LPIP_OP_DIV, ALU_OP_UU, 1'b0, 64'd100, 64'd7, 5'd3, 64'd14);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_ready", {63'b0, bus.req_ready}, 64'd1);
    check("flush_busy", {63'b0, busy}, 64'd0);
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) saw = 1'b1;
    end
    check("flush_no_valid", {63'b0, saw}, 64'd0);
    void'(exp_q.pop_back());
    void'(tag_q.pop_back());

    // asynchronous reset in the middle of CALC
    issue("arst", LPIP_OP_DIV, ALU_OP_UU, 1'b0, 64'd1000, 64'd10, 5'd4, 64'd100);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check("arst_result", bus.rsp_result, 64'd0);
    check("arst_rd_idx", {59'b0, bus.rsp_rd_idx}, 64'd0);
    check("arst_busy", {63'b0, busy}, 64'd0);
    void'(exp_q.pop_back());
    void'(tag_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", LPIP_OP_DIV, ALU_OP_UU, 1'b0, 64'd1000, 64'd10, 5'd4, 64'd100, LAT64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
